// File: rtl/fnv_pkg.sv
// rtl/fnv_pkg.sv - shared types, FNV-1a constants and round-robin pick for the hash arbiter
//
// Contents:
//   arb_state_t     arbiter FSM state encoding
//   FnvOffsetBasis  FNV-1a 32-bit initial hash value
//   FnvPrime        FNV-1a 32-bit multiplier
//   MaxReq          largest supported requester count
//   rr_pick()       first valid requester at or after ptr, wrapping modulo num_req
package fnv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    STREAM,
    DONE
  } arb_state_t;

  localparam logic [31:0] FnvOffsetBasis = 32'h811C9DC5;
  localparam logic [31:0] FnvPrime       = 32'd16777619;
  localparam int unsigned MaxReq         = 4;

  // Scans valid[] starting at ptr. ptr and every offset are below num_req,
  // so one conditional subtraction is enough for the wrap. When nothing is
  // valid the result is ptr; callers qualify with |valid.
  function automatic logic [1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                         input logic [1:0]        ptr,
                                         input int unsigned       num_req);
    logic [1:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(num_req)) begin
        idx = idx - 3'(num_req);
      end
      if (!found && (k < num_req) && valid[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fnv_1a_32.sv
// rtl/fnv_1a_32.sv - 32-bit FNV-1a hashing core, one byte per enabled cycle
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high init, loads the offset basis
//   en       fold data_in into the hash this cycle
//   data_in  byte to hash
//   hash     current 32-bit hash state
module fnv_1a_32
  import fnv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] hash
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hash <= FnvOffsetBasis;
    end else if (en) begin
      hash <= (hash ^ {24'h0, data_in}) * FnvPrime;
    end
  end

endmodule

// File: rtl/fnv_hash_arbiter.sv
// rtl/fnv_hash_arbiter.sv - round-robin arbiter sharing one FNV-1a core between byte requesters
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester byte valid
//   req_data   per-requester byte, requester i on bits [8i+7:8i]
//   req_last   marks the final byte of a message
//   req_ready  byte accepted when valid & ready (only the granted requester)
//   dig_valid  digest available
//   dig_ready  consumer takes the digest
//   dig_hash   FNV-1a digest
//   dig_id     requester that owns the digest
//   dig_len    bytes hashed, saturating at all-ones
//   busy       high in any state except IDLE
module fnv_hash_arbiter
  import fnv_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdW    = 2,
  parameter int LenW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NumReq-1:0]   req_valid,
  input  logic [NumReq*8-1:0] req_data,
  input  logic [NumReq-1:0]   req_last,
  output logic [NumReq-1:0]   req_ready,
  output logic                dig_valid,
  input  logic                dig_ready,
  output logic [31:0]         dig_hash,
  output logic [IdW-1:0]      dig_id,
  output logic [LenW-1:0]     dig_len,
  output logic                busy
);

  arb_state_t     state;
  logic [IdW-1:0] grant;
  logic [IdW-1:0] rr_ptr;
  logic [LenW-1:0] len;

  logic           gnt_valid;
  logic           gnt_last;
  logic [7:0]     gnt_data;
  logic [1:0]     pick;
  logic           core_rst;
  logic           core_en;
  logic [31:0]    core_hash;

  // Mux the granted requester's byte lane.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = 8'h00;
    for (int i = 0; i < NumReq; i++) begin
      if (grant == IdW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[8*i +: 8];
      end
    end
  end

  assign pick = rr_pick(MaxReq'(req_valid), 2'(rr_ptr), NumReq);

  // The core is held in init through IDLE as well as INIT. Since rst_n forces
  // the state to IDLE, this also keeps the core in init while rst_n is low
  // without routing the async reset into a synchronous input.
  assign core_rst = (state == IDLE) || (state == INIT);
  assign core_en  = (state == STREAM) && gnt_valid;

  fnv_1a_32 u_core (
    .clk     (clk),
    .rst     (core_rst),
    .en      (core_en),
    .data_in (gnt_data),
    .hash    (core_hash)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      len    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= IdW'(pick);
            state <= INIT;
          end
        end
        INIT: begin
          len   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (gnt_valid) begin
            if (len != '1) begin
              len <= len + LenW'(1);
            end
            if (gnt_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (dig_ready) begin
            rr_ptr <= (grant == IdW'(NumReq - 1)) ? '0 : grant + IdW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state flops: no input-to-output path,
  // and they fall to zero the moment rst_n asserts.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NumReq; i++) begin
      if ((state == STREAM) && (grant == IdW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dig_valid = (state == DONE);
  assign dig_hash  = dig_valid ? core_hash : '0;
  assign dig_id    = dig_valid ? grant : '0;
  assign dig_len   = dig_valid ? len : '0;

endmodule

// File: tb/tb_fnv_hash_arbiter.sv
// tb/tb_fnv_hash_arbiter.sv - directed self-checking bench for fnv_hash_arbiter
module tb_fnv_hash_arbiter;

  localparam int N = 2;
  localparam logic [31:0] HashA      = 32'hE40C292C;
  localparam logic [31:0] HashB      = 32'hE70C2DE5;
  localparam logic [31:0] HashFoobar = 32'hBF9CF968;

  logic           clk = 1'b0;
  logic           rst_n;

  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           dig_valid;
  logic           dig_ready;
  logic [31:0]    dig_hash;
  logic [1:0]     dig_id;
  logic [15:0]    dig_len;
  logic           busy;

  logic [N-1:0]   s_req_valid;
  logic [N*8-1:0] s_req_data;
  logic [N-1:0]   s_req_last;
  logic [N-1:0]   s_req_ready;
  logic           s_dig_valid;
  logic           s_dig_ready;
  logic [31:0]    s_dig_hash;
  logic [1:0]     s_dig_id;
  logic [3:0]     s_dig_len;
  logic           s_busy;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [7:0]  msg [0:31];
  int          msg_n;
  logic        bad_ready;
  logic [7:0]  sbytes [0:19];

  always #5 clk = ~clk;

  fnv_hash_arbiter #(.NumReq(N), .IdW(2), .LenW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_hash  (dig_hash),
    .dig_id    (dig_id),
    .dig_len   (dig_len),
    .busy      (busy)
  );

  fnv_hash_arbiter #(.NumReq(N), .IdW(2), .LenW(4)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (s_req_valid),
    .req_data  (s_req_data),
    .req_last  (s_req_last),
    .req_ready (s_req_ready),
    .dig_valid (s_dig_valid),
    .dig_ready (s_dig_ready),
    .dig_hash  (s_dig_hash),
    .dig_id    (s_dig_id),
    .dig_len   (s_dig_len),
    .busy      (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // FNV-1a step with the prime multiply written as shift-adds (2^24+2^8+2^7+2^4+2^1+1).
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'h0, b};
    return x + (x << 1) + (x << 4) + (x << 7) + (x << 8) + (x << 24);
  endfunction

  task automatic load(input string s);
    msg_n = s.len();
    for (int i = 0; i < s.len(); i++) msg[i] = s[i];
  endtask

  // Streams msg[0..n-1] on port p, one decision per negedge. After byte gap_idx
  // is accepted, valid drops for gap_cyc cycles with last held high.
  task automatic stream_msg(input string tag, input int p, input int n, input bit with_last,
                            input int gap_idx, input int gap_cyc);
    int i;
    int budget;
    int gap_left;
    logic acc;
    i = 0; budget = 0; gap_left = 0;
    while (i < n && budget < 100) begin
      if (gap_left > 0) begin
        req_valid[p] = 1'b0;
        req_last[p]  = 1'b1;
        gap_left--;
      end else begin
        req_valid[p]         = 1'b1;
        req_data[8*p +: 8]   = msg[i];
        req_last[p]          = with_last && (i == n - 1);
      end
      if (req_ready != '0 && req_ready != (N'(1) << p)) bad_ready = 1'b1;
      acc = req_valid[p] && req_ready[p];
      @(negedge clk);
      budget++;
      if (acc) begin
        if (i == gap_idx) gap_left = gap_cyc;
        i++;
      end
    end
    req_valid[p] = 1'b0;
    req_last[p]  = 1'b0;
    check({tag, "_bytes"}, i, n);
  endtask

  task automatic check_digest(input string tag, input int id, input logic [31:0] h, input int len);
    check({tag, "_valid"}, dig_valid, 1);
    check({tag, "_hash"}, dig_hash, h);
    check({tag, "_id"}, dig_id, id);
    check({tag, "_len"}, dig_len, len);
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    check({tag, "_idle"}, {busy, dig_valid}, 0);
  endtask

  // Waits for a grant, expects it on exp_id, lets the pending single byte go.
  task automatic serve_one(input int exp_id, input logic [31:0] h, input string tag);
    int n;
    n = 0;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, req_ready, N'(1) << exp_id);
    @(negedge clk);
    req_valid[exp_id] = 1'b0;
    req_last[exp_id]  = 1'b0;
    check_digest(tag, exp_id, h, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int budget;
    logic acc;
    logic [31:0] exp_s;

    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; dig_ready = 1'b0;
    s_req_valid = '0; s_req_last = '0; s_req_data = '0; s_dig_ready = 1'b0;
    bad_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", req_ready, 0);
    check("rst_dig", {dig_valid, busy}, 0);
    check("rst_hash", dig_hash, 0);
    check("rst_idlen", {dig_id, dig_len}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Single-byte "a" on req0
    load("a");
    stream_msg("a0", 0, 1, 1'b1, -1, 0);
    check_digest("a0", 0, HashA, 1);

    // "foobar" on req1 with a 2-cycle gap after the second 'o'
    load("foobar");
    bad_ready = 1'b0;
    stream_msg("foobar", 1, 6, 1'b1, 2, 2);
    check("foobar_only_rdy1", bad_ready, 0);
    check_digest("foobar", 1, HashFoobar, 6);

    // Round-robin ordering from a fresh reset
    do_reset();
    req_data = {8'h62, 8'h61};
    req_last = 2'b11; req_valid = 2'b11;
    serve_one(0, HashA, "rr1_0");
    serve_one(1, HashB, "rr1_1");
    req_last = 2'b11; req_valid = 2'b11;
    serve_one(0, HashA, "rr2_0");
    serve_one(1, HashB, "rr2_1");
    req_last[0] = 1'b1; req_valid[0] = 1'b1;
    serve_one(0, HashA, "rr3_0");
    req_last = 2'b11; req_valid = 2'b11;
    serve_one(1, HashB, "rr4_1");
    serve_one(0, HashA, "rr4_0");

    // Digest held for 5 cycles with another requester waiting
    req_data[7:0] = 8'h61; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hold_grant", req_ready, 2'b01);
    req_data[15:8] = 8'h62; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", dig_valid, 1);
      check("hold_hash", dig_hash, HashA);
      check("hold_idlen", {dig_id, dig_len}, {2'd0, 16'd1});
      check("hold_nogrant", req_ready, 0);
      @(negedge clk);
    end
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    check("hold_release", {busy, dig_valid}, 0);
    serve_one(1, HashB, "hold_b");

    // Reset in the middle of a stream
    load("foobar");
    stream_msg("rst_pre", 1, 3, 1'b0, -1, 0);
    check("rst_pre_rdy", req_ready, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_async_rdy", req_ready, 0);
    check("rst_async_st", {busy, dig_valid}, 0);
    check("rst_async_hash", dig_hash, 0);
    repeat (2) @(negedge clk);
    req_valid = '0; req_last = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_dig", {busy, dig_valid}, 0);
    load("a");
    stream_msg("rst_a", 0, 1, 1'b1, -1, 0);
    check_digest("rst_a", 0, HashA, 1);

    // 20-byte message into the LenW=4 instance: length saturates at 15
    exp_s = 32'h811C9DC5;
    for (int k = 0; k < 20; k++) begin
      sbytes[k] = 8'(k * 7 + 3);
      exp_s = fnv_step(exp_s, sbytes[k]);
    end
    n = 0; budget = 0;
    while (n < 20 && budget < 100) begin
      s_req_valid[0]   = 1'b1;
      s_req_data[7:0]  = sbytes[n];
      s_req_last[0]    = (n == 19);
      acc = s_req_ready[0];
      @(negedge clk);
      budget++;
      if (acc) n++;
    end
    s_req_valid = '0; s_req_last = '0;
    check("sat_bytes", n, 20);
    check("sat_valid", s_dig_valid, 1);
    check("sat_hash", s_dig_hash, exp_s);
    check("sat_len", s_dig_len, 4'hF);
    check("sat_id", s_dig_id, 0);
    s_dig_ready = 1'b1;
    @(negedge clk);
    s_dig_ready = 1'b0;
    check("sat_idle", {s_busy, s_dig_valid}, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fnv_hash_arbiter.md
Name: fnv_hash_arbiter

Overview:
- Shares one `fnv_1a_32` hashing core between `NumReq` byte-stream requesters.
- Arbitrates round-robin between requesters and sequences the core: init, stream, digest.
- Returns a 32-bit digest tagged with the requester id and byte count.
- Sits between the I2C byte front-end(s) and the result register file.

Parameters:
- NumReq, 2, number of requesters (2..4).
- IdW, 2, width of the requester id; must satisfy 2**IdW >= NumReq.
- LenW, 16, width of the byte counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NumReq  per-requester byte valid
- req_data  in  NumReq*8  per-requester byte, requester i on bits [8i+7:8i]
- req_last  in  NumReq  marks the final byte of a message
- req_ready  out  NumReq  byte accepted when valid&ready
- dig_valid  out  1  digest available
- dig_ready  in  1  consumer takes digest
- dig_hash  out  32  FNV-1a digest
- dig_id  out  IdW  index of the requester that owns the digest
- dig_len  out  LenW  bytes hashed, saturating at all-ones
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr_ptr=0, all outputs 0, core held in init.
- States:
  - IDLE: scan req_valid starting at rr_ptr, wrap modulo NumReq; first set bit wins. Latch grant id, go to INIT. No valid -> stay.
  - INIT: one cycle. Drive the core's sync init so hash=0x811C9DC5. Clear len. req_ready all 0. Next state: STREAM.
  - STREAM: req_ready[grant]=1, all other bits 0. On req_valid[grant]: core enable=1, in=byte, len+1 (saturating). If that byte also has req_last, go to DONE. Gaps (valid low) are allowed; the hash holds.
  - DONE: dig_valid=1; dig_hash=core out (settled, 1 cycle after the last byte); dig_id=grant; dig_len=len. On dig_ready: set rr_ptr=grant+1 (mod NumReq) and go to IDLE.
- DONE outputs stay stable while dig_valid && !dig_ready.
- Core reset is driven from the FSM only. The core's sync reset is asserted combinationally in INIT, and also while rst_n is low.
- Latency: grant to first accept = 2 cycles (IDLE to INIT to STREAM). Last byte to dig_valid = 1 cycle.
- Minimum period per message = len + 3 cycles.
- Boundary conditions:
  - Single-byte message (valid & last on the first STREAM cycle) is legal.
  - Zero-length messages are not expressible.
  - req_last without req_valid is ignored.
  - Requests from non-granted ports stall (ready=0); their data must be held stable by the requester.
  - A granted requester dropping valid mid-message leaves the arbiter waiting in STREAM indefinitely.
  - len saturates at 2**LenW-1; hashing continues past saturation.
  - Simultaneous requests: grant follows rr_ptr order.
  - Reset mid-STREAM or mid-DONE: immediate return to IDLE; the digest is discarded and no dig_valid is issued.
- Invariants:
  - At most one req_ready bit set.
  - req_ready=0 outside STREAM.
  - dig_valid only in DONE.
- Arithmetic is done in the core (32-bit xor then multiply by 16777619, mod 2**32). This block does no arithmetic beyond len+1 and the modulo-NumReq pointer increment.

Decomposition:
- Package fnv_pkg:
  - state enum typedef `arb_state_t {IDLE, INIT, STREAM, DONE}`
  - constants `FnvOffsetBasis` = 32'h811C9DC5 and `FnvPrime` = 32'd16777619
  - function `rr_pick(valid, ptr)` returning the winning id
- One sub-module instance: the existing `fnv_1a_32` core (sync active-high reset, enable, 8-bit in, 32-bit out).
- Arbiter, FSM and counters live in this module.

Test Plan:
- Req0 sends "a" (0x61, last) -> dig_valid 1 cycle after accept; dig_hash=0xE40C292C, dig_id=0, dig_len=1.
- Req1 sends "foobar" with a 2-cycle gap after 'o' -> dig_hash=0xBF9CF968, dig_id=1, dig_len=6; only req_ready[1] ever high.
- Req0 and req1 both valid in IDLE after reset -> req0 served first, then req1. Repeat with both valid -> req0 is served next; the rr_ptr scan order is verified.
- Hold dig_ready=0 for 5 cycles in DONE -> dig_* stable and no new grant. Raise dig_ready -> IDLE next cycle.
- Pull rst_n low mid-STREAM after 3 bytes -> outputs 0 asynchronously. Resend "a" -> digest 0xE40C292C, proving the core was re-initialised.
- LenW=4, 20-byte message -> dig_len=15 (saturated); dig_hash matches the golden model for all 20 bytes.
